// File: rtl/down_counter_reload_if.sv
// ============================================================================
// down_counter_reload_if : control/status bundle for down_counter_reload
// Revision 1.0
// ============================================================================
`default_nettype none

interface down_counter_reload_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             borrow;
  logic             done;
  logic             busy;

  modport master (
    output en, load, load_val, auto_reload,
    input  q, zero, borrow, done, busy
  );

  modport slave (
    input  en, load, load_val, auto_reload,
    output q, zero, borrow, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/down_counter_reload.sv
// ============================================================================
// down_counter_reload : loadable down counter, one-shot or auto-reload mode
// Revision 1.0
// ============================================================================
`default_nettype none

module down_counter_reload #(
  parameter int WIDTH = 3
) (
  input  wire                 clk,
  input  wire                 rst,
  down_counter_reload_if.slave bus
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rl;
  logic             r_borrow;
  logic             r_done;
  logic             r_busy;
  logic [WIDTH-1:0] w_wrap;

  // A cleared reload register turns the block into a free-running modulo counter.
  assign w_wrap = (r_rl != c_ZERO) ? r_rl : c_MAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= c_ZERO;
      r_rl     <= c_ZERO;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      if (bus.load) begin
        r_q     <= bus.load_val;
        r_rl    <= bus.load_val;
        r_state <= S_RUN;
        r_busy  <= 1'b1;
      end else if (bus.en) begin
        case (r_state)
          S_IDLE: begin
            if (bus.auto_reload) begin
              r_q      <= w_wrap;
              r_borrow <= 1'b1;
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
            end
          end
          S_RUN: begin
            if (r_q > c_ONE) begin
              r_q <= r_q - c_ONE;
            end else if (r_q == c_ONE) begin
              r_q <= c_ZERO;
              if (!bus.auto_reload) begin
                r_state <= S_HALT;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else if (bus.auto_reload) begin
              r_q      <= w_wrap;
              r_borrow <= 1'b1;
            end else begin
              r_state <= S_HALT;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_q <= c_ZERO;
          end
        endcase
      end
    end
  end

  assign bus.q      = r_q;
  assign bus.zero   = (r_q == c_ZERO);
  assign bus.borrow = r_borrow;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_down_counter_reload.sv
// ============================================================================
// tb_down_counter_reload : directed vectors with a queue-based scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_down_counter_reload;

  localparam int c_WIDTH = 3;

  typedef struct {
    string            name;
    logic [c_WIDTH-1:0] q;
    logic             zero;
    logic             borrow;
    logic             done;
    logic             busy;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  bit   stim_done;

  down_counter_reload_if #(.WIDTH(c_WIDTH)) bus ();

  down_counter_reload #(.WIDTH(c_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge and queue what the next rising edge must produce.
  task automatic vec(input string nm, input logic r, input logic e, input logic ld,
                     input logic [c_WIDTH-1:0] lv, input logic ar,
                     input logic [c_WIDTH-1:0] eq, input logic eb, input logic ed,
                     input logic ebusy);
    exp_t x;
    @(negedge clk);
    rst             = r;
    bus.en          = e;
    bus.load        = ld;
    bus.load_val    = lv;
    bus.auto_reload = ar;
    x.name   = nm;
    x.q      = eq;
    x.zero   = (eq == '0);
    x.borrow = eb;
    x.done   = ed;
    x.busy   = ebusy;
    sb_q.push_back(x);
  endtask

  // Monitor: every rising edge presents a new output word.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_vec++;
      if (bus.q !== x.q || bus.zero !== x.zero || bus.borrow !== x.borrow ||
          bus.done !== x.done || bus.busy !== x.busy) begin
        n_err++;
        $display("FAIL %s: got q=%0d z=%b b=%b d=%b busy=%b, want q=%0d z=%b b=%b d=%b busy=%b",
                 x.name, bus.q, bus.zero, bus.borrow, bus.done, bus.busy,
                 x.q, x.zero, x.borrow, x.done, x.busy);
      end
    end
  end

  logic [c_WIDTH-1:0] t1_seq [10];
  logic [c_WIDTH-1:0] t3_seq [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    stim_done = 1'b0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.auto_reload = 1'b0;

    t1_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    t3_seq = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3};

    // 1: reset, then free-running wrap from rl=0
    vec("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("idle_en_oneshot", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      vec("freerun", 0, 1, 0, 0, 1, t1_seq[i], t1_seq[i] == 3'd7, 0, 1);

    // 2: one-shot from 5
    vec("os_load5", 0, 0, 1, 5, 0, 5, 0, 0, 1);
    vec("os_4", 0, 1, 0, 0, 0, 4, 0, 0, 1);
    vec("os_3", 0, 1, 0, 0, 0, 3, 0, 0, 1);
    vec("os_2", 0, 1, 0, 0, 0, 2, 0, 0, 1);
    vec("os_1", 0, 1, 0, 0, 0, 1, 0, 0, 1);
    vec("os_done", 0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      vec("halt_hold", 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // 3: auto-reload at 3, load wins over en
    vec("ar_load3", 0, 1, 1, 3, 1, 3, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      vec("ar_cycle", 0, 1, 0, 0, 1, t3_seq[i], t3_seq[i] == 3'd3, 0, 1);

    // 4: load during count, new wrap value 6
    vec("q2", 0, 1, 0, 0, 1, 2, 0, 0, 1);
    vec("load6_over_en", 0, 1, 1, 6, 1, 6, 0, 0, 1);
    vec("after_load_5", 0, 1, 0, 0, 1, 5, 0, 0, 1);
    vec("w6_4", 0, 1, 0, 0, 1, 4, 0, 0, 1);
    vec("w6_3", 0, 1, 0, 0, 1, 3, 0, 0, 1);
    vec("w6_2", 0, 1, 0, 0, 1, 2, 0, 0, 1);
    vec("w6_1", 0, 1, 0, 0, 1, 1, 0, 0, 1);
    vec("w6_0", 0, 1, 0, 0, 1, 0, 0, 0, 1);
    vec("wrap6", 0, 1, 0, 0, 1, 6, 1, 0, 1);

    // 5: reset mid-count beats a load, clearing rl
    vec("mode_sw_5", 0, 1, 0, 0, 0, 5, 0, 0, 1);
    vec("mode_sw_4", 0, 1, 0, 0, 0, 4, 0, 0, 1);
    vec("rst_over_load", 1, 1, 1, 5, 0, 0, 0, 0, 0);
    vec("idle_wrap7", 0, 1, 0, 0, 1, 7, 1, 0, 1);

    // 6: hold with en low, then load 0 and terminate
    vec("load4", 0, 0, 1, 4, 1, 4, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      vec("hold4", 0, 0, 0, 0, 1, 4, 0, 0, 1);
    vec("load0", 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vec("q0_oneshot_done", 0, 1, 0, 0, 0, 0, 0, 1, 0);
    vec("halt_ignore_en", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    vec("halt_load0", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    vec("rl0_wrap7", 0, 1, 0, 0, 1, 7, 1, 0, 1);
    vec("idle_input", 0, 0, 0, 0, 1, 7, 0, 0, 1);

    stim_done = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
Synchronous, loadable down counter. It counts in the opposite direction to the team's ripple up counters and produces the terminal-count signalling that timer and delay consumers need. It supports two modes, selected each cycle by auto_reload: one-shot (count to 0, then halt) and auto-reload (wrap to a stored reload value). All state lives in one clock domain, so it is safe to drive downstream synchronous logic directly.

Parameters:
WIDTH, 3, counter and load-value width in bits (WIDTH >= 2).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
en  input  1  count enable; one decrement per cycle while high.
load  input  1  load request; copies load_val into q and into the reload register.
load_val  input  WIDTH  value captured on load.
auto_reload  input  1  1 = wrap mode, 0 = one-shot mode; sampled every cycle.
q  output  WIDTH  current count, registered.
zero  output  1  combinational (q == 0).
borrow  output  1  registered one-cycle pulse on each wrap.
done  output  1  registered one-cycle pulse when one-shot mode terminates.
busy  output  1  registered; high while state == RUN.

Behaviour:
- Reset values: q=0, reload register rl=0, state=IDLE, borrow=0, done=0, busy=0, zero=1.
- Priority each edge: rst > load > en. With en=0 and load=0, q, rl and state hold, and borrow/done are 0.
- Wrap value: W = rl if rl != 0, else 2^WIDTH-1. With rl=0 the block is a free-running modulo-2^WIDTH down counter.
- States:
  - IDLE (after reset):
    - load -> RUN, q=load_val, rl=load_val.
    - en & auto_reload -> RUN, q=W, borrow=1.
    - en & !auto_reload -> stay IDLE, no change.
  - RUN:
    - load -> q=load_val, rl=load_val, stay RUN, no pulses.
    - en & q>1 -> q=q-1.
    - en & q==1 & !auto_reload -> q=0, HALT, done=1.
    - en & q==1 & auto_reload -> q=0, stay RUN.
    - en & q==0 & auto_reload -> q=W, borrow=1.
    - en & q==0 & !auto_reload -> HALT, done=1, q stays 0.
  - HALT:
    - q held at 0, en ignored, no pulses.
    - load -> RUN with load_val, even if load_val=0.
- Pulse timing:
  - borrow is high in exactly the cycle q first shows W.
  - done is high in exactly the cycle state first shows HALT.
  - Each pulse is never longer than one cycle per event.
- busy is registered and reflects state after the edge; it falls in the same cycle done rises.
- Mode change: auto_reload affects only the decision at q==1 or q==0; toggling it mid-count does not disturb q.
- Arithmetic: unsigned WIDTH-bit; no decrement below 0 except via the defined wrap.
- Reset mid-operation: the next edge forces all reset values, including rl=0. A load or en in the same cycle is discarded.

Test Plan:
1. rst 2 cycles; en=1, auto_reload=1, no load (WIDTH=3) -> q: 7,6,5,4,3,2,1,0,7,...; borrow=1 only in cycles where q becomes 7; busy=1 from first edge.
2. load_val=5, auto_reload=0, then en=1 -> q: 5,4,3,2,1,0; done=1 for one cycle coincident with q=0; busy falls the same cycle; 4 further en cycles leave q=0 with no pulses.
3. load_val=3, auto_reload=1, en=1 -> q: 3,2,1,0,3,2,1,0,3; borrow pulses exactly on each 0->3 transition.
4. In RUN with q=2: load=1, en=1, load_val=6 -> q=6, not 1. Next cycle en -> q=5. Wrap value is now 6.
5. Counting one-shot at q=4: assert rst together with load=1 -> q=0, IDLE, busy=0, borrow=done=0. Then en with auto_reload=1 -> q=7 (rl cleared).
6. At q=4 in RUN: en low 3 cycles -> q stays 4 with no pulses. Then load_val=0 with auto_reload=0 and one en -> HALT, done=1, q=0.
